// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg : shared types for the handshaked ALU (alu_pipe) and its sequential
//           multiplier (alu_mul_seq).
//   arith_cmd_t : arithmetic-mode operation codes (mode = 1)
//   logic_cmd_t : logic-mode operation codes (mode = 0)
//   state_t     : pipeline control state {S_IDLE, S_MUL}
//   flags_t     : registered status flags carried with each result
//   ovf()       : two's-complement overflow from operand/result sign bits
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC     = 4'd4,
    A_DEC     = 4'd5,
    A_CMP     = 4'd6,
    A_MUL     = 4'd7
  } arith_cmd_t;

  typedef enum logic [3:0] {
    L_AND  = 4'd0,
    L_NAND = 4'd1,
    L_OR   = 4'd2,
    L_NOR  = 4'd3,
    L_XOR  = 4'd4,
    L_XNOR = 4'd5,
    L_NOT  = 4'd6,
    L_SHR1 = 4'd7,
    L_SHL1 = 4'd8,
    L_ROL  = 4'd9,
    L_ROR  = 4'd10
  } logic_cmd_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic zero;
    logic g;
    logic l;
    logic e;
    logic err;
  } flags_t;

  localparam flags_t FLAGS_CLR = flags_t'(7'b0000000);

  // Overflow of a +/- b given the three sign bits. A subtract is an add of ~b,
  // so the operand signs must differ for a subtract to be able to overflow.
  function automatic logic ovf(input logic a_m, input logic b_m,
                               input logic r_m, input logic is_sub);
    ovf = is_sub ? ((a_m != b_m) && (r_m != a_m))
                 : ((a_m == b_m) && (r_m != a_m));
  endfunction

endpackage

// File: rtl/alu_pipe_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq : registered MUL_LAT-cycle unsigned multiplier.
//   clk, rst   : clock, asynchronous active-high reset (discards any product)
//   cen        : clock enable, freezes all state when low
//   start      : capture opa/opb and begin a multiply
//   opa, opb   : WIDTH-bit unsigned operands
//   done       : product valid; held until the next enabled edge
//   prod       : 2*WIDTH-bit product
// done is high during the MUL_LAT-th enabled cycle after start, so a consumer
// loading prod on that edge sees its result MUL_LAT edges after start.
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               start,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(MUL_LAT);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_prod;

  // Operand capture, latency countdown and product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_prod <= {(2*WIDTH){1'b0}};
    end else if (cen) begin
      if (start) begin
        r_a    <= opa;
        r_b    <= opb;
        r_cnt  <= CNT_W'(MUL_LAT - 1);
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (r_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_prod <= {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end else begin
        r_done <= 1'b0;
      end
    end
  end

  assign done = r_done;
  assign prod = r_prod;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe : handshaked, parametrised ALU with registered result and flags.
//   clk, rst            : clock, asynchronous active-high reset
//   cen                 : clock enable; low freezes state, no accept or take
//   in_valid / in_ready : request handshake (mode, cmd, opa, opb, cin)
//   out_valid/out_ready : result handshake (res, cout, oflow, zero, g, l, e, err)
// Non-MUL ops load the result registers on the accept edge (1-cycle latency,
// 1 op/cycle when the consumer keeps out_ready high).
// Optional feature macro: ALU_PIPE_MUL_EN adds the MUL_LAT-cycle multiply
// (arith cmd 7) through alu_mul_seq; without it cmd 7 reports err.
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [3:0]         cmd,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               cout,
  output logic               oflow,
  output logic               zero,
  output logic               g,
  output logic               l,
  output logic               e,
  output logic               err
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_res;
  flags_t             r_flags;

  logic               w_accept;
  logic               w_take;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_p;
  flags_t             w_mul_flags;

  logic               w_inc_dec;
  logic [WIDTH-1:0]   w_b_op;
  logic               w_c_in;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [2*WIDTH-1:0] w_rol2;
  logic [2*WIDTH-1:0] w_ror2;
  logic               w_rot_err;
  logic [WIDTH-1:0]   w_res_n;
  flags_t             w_flags_n;

  assign w_accept = cen && in_valid && in_ready;
  assign w_take   = cen && r_out_valid && out_ready;

`ifdef ALU_PIPE_MUL_EN
  assign w_is_mul = mode && (cmd == A_MUL);

  alu_mul_seq #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .start (w_accept && w_is_mul),
    .opa   (opa),
    .opb   (opb),
    .done  (w_mul_done),
    .prod  (w_mul_p)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_p    = {(2*WIDTH){1'b0}};
`endif

  // INC/DEC reuse the add/sub datapath with b = 1; only the *_CIN ops see cin.
  assign w_inc_dec = (cmd == A_INC) || (cmd == A_DEC);
  assign w_b_op    = w_inc_dec ? ONE : opb;
  assign w_c_in    = ((cmd == A_ADD_CIN) || (cmd == A_SUB_CIN)) ? cin : 1'b0;
  assign w_sum     = {1'b0, opa} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_c_in};
  // Bit WIDTH of the widened difference is the borrow.
  assign w_dif     = {1'b0, opa} - {1'b0, w_b_op} - {{WIDTH{1'b0}}, w_c_in};

  // Rotating a doubled copy leaves the rotated word in one half.
  assign w_rol2    = {opa, opa} << opb[SH_W-1:0];
  assign w_ror2    = {opa, opa} >> opb[SH_W-1:0];
  assign w_rot_err = |opb[WIDTH-1:SH_W];

  // Single-cycle result and flags for the operation presented at the input.
  always_comb begin
    w_res_n   = {WIDTH{1'b0}};
    w_flags_n = FLAGS_CLR;
    if (mode) begin
      case (cmd)
        A_ADD, A_ADD_CIN, A_INC: begin
          w_res_n         = w_sum[WIDTH-1:0];
          w_flags_n.cout  = w_sum[WIDTH];
          w_flags_n.oflow = ovf(opa[WIDTH-1], w_b_op[WIDTH-1], w_sum[WIDTH-1], 1'b0);
        end
        A_SUB, A_SUB_CIN, A_DEC: begin
          w_res_n         = w_dif[WIDTH-1:0];
          w_flags_n.cout  = w_dif[WIDTH];
          w_flags_n.oflow = ovf(opa[WIDTH-1], w_b_op[WIDTH-1], w_dif[WIDTH-1], 1'b1);
        end
        A_CMP: begin
          w_flags_n.g = (opa > opb);
          w_flags_n.l = (opa < opb);
          w_flags_n.e = (opa == opb);
        end
        default: w_flags_n.err = 1'b1;
      endcase
    end else begin
      case (cmd)
        L_AND:  w_res_n = opa & opb;
        L_NAND: w_res_n = ~(opa & opb);
        L_OR:   w_res_n = opa | opb;
        L_NOR:  w_res_n = ~(opa | opb);
        L_XOR:  w_res_n = opa ^ opb;
        L_XNOR: w_res_n = ~(opa ^ opb);
        L_NOT:  w_res_n = ~opa;
        L_SHR1: w_res_n = opa >> 1;
        L_SHL1: w_res_n = opa << 1;
        L_ROL: begin
          if (w_rot_err) w_flags_n.err = 1'b1;
          else           w_res_n = w_rol2[2*WIDTH-1:WIDTH];
        end
        L_ROR: begin
          if (w_rot_err) w_flags_n.err = 1'b1;
          else           w_res_n = w_ror2[WIDTH-1:0];
        end
        default: w_flags_n.err = 1'b1;
      endcase
    end
    w_flags_n.zero = (w_res_n == {WIDTH{1'b0}}) && !w_flags_n.err;

    w_mul_flags      = FLAGS_CLR;
    w_mul_flags.zero = (w_mul_p == {(2*WIDTH){1'b0}});
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= S_IDLE;
    else if (cen) r_state <= w_state_nxt;
  end

  // Next state: a multiply accept enters S_MUL until its product is loaded.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) w_state_nxt = S_MUL;
        else                      w_state_nxt = S_IDLE;
      end
      S_MUL: begin
        if (w_mul_done) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_MUL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Input readiness: free output, or one being taken this cycle.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = !r_out_valid || out_ready;
      S_MUL:   in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Result/flag registers: new completion wins over a take, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_res       <= {(2*WIDTH){1'b0}};
      r_flags     <= FLAGS_CLR;
    end else if (cen) begin
      if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_res       <= {{WIDTH{1'b0}}, w_res_n};
        r_flags     <= w_flags_n;
      end else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_res       <= w_mul_p;
        r_flags     <= w_mul_flags;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign cout      = r_flags.cout;
  assign oflow     = r_flags.oflow;
  assign zero      = r_flags.zero;
  assign g         = r_flags.g;
  assign l         = r_flags.l;
  assign e         = r_flags.e;
  assign err       = r_flags.err;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe : directed self-checking bench for alu_pipe (WIDTH=8, MUL_LAT=3).
// Observed word: {out_valid, res[15:0], cout, oflow, zero, g, l, e, err}.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [3:0]  cmd;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic        cout, oflow, zero, g, l, e, err;
  logic [23:0] obs;

  int n_vec = 0;
  int n_err = 0;

  alu_pipe #(.WIDTH(8), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .cen(cen), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .cmd(cmd), .opa(opa), .opb(opb), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .cout(cout), .oflow(oflow), .zero(zero), .g(g), .l(l), .e(e), .err(err)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, res, cout, oflow, zero, g, l, e, err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cen = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 1'b0; cmd = 4'd0; opa = 8'h00; opb = 8'h00; cin = 1'b0;
    #3;
    n_vec++;
    if ({in_ready, obs} !== {1'b1, 24'h000000}) begin
      $display("FAIL reset_async: got %h expected %h", {in_ready, obs}, {1'b1, 24'h000000}); n_err++;
    end
    tick;
    n_vec++;
    if ({in_ready, obs} !== {1'b1, 24'h000000}) begin
      $display("FAIL reset_clocked: got %h expected %h", {in_ready, obs}, {1'b1, 24'h000000}); n_err++;
    end
    rst = 1'b0;
  endtask

  task automatic test_arith;
    logic [3:0]  c [9];
    logic [7:0]  a [9];
    logic [7:0]  b [9];
    logic        ci [9];
    logic [23:0] x [9];
    c  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
    a  = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h10, 8'h10, 8'hFF, 8'h80, 8'h12};
    b  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h20, 8'h10, 8'h00, 8'h00, 8'h34};
    ci = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    x  = '{{1'b1, 16'h0000, 7'b1010000},   // ADD FF+01: carry, zero
           {1'b1, 16'h0080, 7'b0100000},   // ADD 7F+01: overflow
           {1'b1, 16'h00FF, 7'b1000000},   // SUB 00-01: borrow
           {1'b1, 16'h007F, 7'b0100000},   // SUB 80-01: overflow
           {1'b1, 16'h0031, 7'b0000000},   // ADD_CIN 10+20+1
           {1'b1, 16'h00FF, 7'b1000000},   // SUB_CIN 10-10-1: borrow
           {1'b1, 16'h0000, 7'b1010000},   // INC FF (cin ignored)
           {1'b1, 16'h007F, 7'b0100000},   // DEC 80: overflow
           {1'b1, 16'h0000, 7'b0000001}};  // arith cmd 9: illegal
    out_ready = 1'b1; mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cmd = c[i]; opa = a[i]; opb = b[i]; cin = ci[i];
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        $display("FAIL arith_ready[%0d]: got %b expected 1", i, in_ready); n_err++;
      end
      tick;
      n_vec++;
      if (obs !== x[i]) begin
        $display("FAIL arith[%0d]: got %h expected %h", i, obs, x[i]); n_err++;
      end
    end
    in_valid = 1'b0; cin = 1'b0;
    tick;
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL arith_drain: out_valid got %b expected 0", out_valid); n_err++;
    end
  endtask

  task automatic test_logic;
    logic [3:0]  c [12];
    logic [7:0]  a [12];
    logic [7:0]  b [12];
    logic [23:0] x [12];
    c = '{4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd9, 4'd10, 4'd9, 4'd12};
    a = '{8'hF0, 8'hFF, 8'hA5, 8'h0F, 8'h81, 8'h41, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h55};
    b = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h07, 8'h08, 8'h55};
    x = '{{1'b1, 16'h00CF, 7'b0000000},   // NAND
          {1'b1, 16'h0000, 7'b0010000},   // NOR -> zero
          {1'b1, 16'h00FF, 7'b0000000},   // XNOR
          {1'b1, 16'h00F0, 7'b0000000},   // NOT_A
          {1'b1, 16'h0040, 7'b0000000},   // SHR1
          {1'b1, 16'h0082, 7'b0000000},   // SHL1
          {1'b1, 16'h0003, 7'b0000000},   // ROL 81 by 1
          {1'b1, 16'h00C0, 7'b0000000},   // ROR 81 by 1
          {1'b1, 16'h0081, 7'b0000000},   // ROL by 0
          {1'b1, 16'h0003, 7'b0000000},   // ROR by 7
          {1'b1, 16'h0000, 7'b0000001},   // ROL by 8: err, zero 0
          {1'b1, 16'h0000, 7'b0000001}};  // logic cmd 12: err, zero 0
    out_ready = 1'b1; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cmd = c[i]; opa = a[i]; opb = b[i];
      tick;
      n_vec++;
      if (obs !== x[i]) begin
        $display("FAIL logic[%0d]: got %h expected %h", i, obs, x[i]); n_err++;
      end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic        m [5];
    logic [3:0]  c [5];
    logic [7:0]  a [5];
    logic [7:0]  b [5];
    logic [23:0] x [5];
    m = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    c = '{4'd0, 4'd4, 4'd6, 4'd6, 4'd6};
    a = '{8'h12, 8'hF0, 8'h10, 8'h55, 8'h20};
    b = '{8'h34, 8'h3C, 8'h20, 8'h55, 8'h10};
    x = '{{1'b1, 16'h0046, 7'b0000000},   // ADD
          {1'b1, 16'h00CC, 7'b0000000},   // XOR
          {1'b1, 16'h0000, 7'b0010100},   // CMP less
          {1'b1, 16'h0000, 7'b0010010},   // CMP equal
          {1'b1, 16'h0000, 7'b0011000}};  // CMP greater
    out_ready = 1'b1; in_valid = 1'b1; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = m[i]; cmd = c[i]; opa = a[i]; opb = b[i];
      tick;
      n_vec++;
      if ({in_ready, obs} !== {1'b1, x[i]}) begin
        $display("FAIL b2b[%0d]: got %h expected %h", i, {in_ready, obs}, {1'b1, x[i]}); n_err++;
      end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; cmd = 4'd0; opa = 8'hF0; opb = 8'h3C;
    tick;
    cmd = 4'd2;  // OR waits behind the held AND result
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); n_err++;
      end
      tick;
      n_vec++;
      if (obs !== {1'b1, 16'h0030, 7'b0000000}) begin
        $display("FAIL bp_hold[%0d]: got %h expected %h", i, obs, {1'b1, 16'h0030, 7'b0000000}); n_err++;
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL bp_resume_ready: got %b expected 1", in_ready); n_err++;
    end
    tick;
    n_vec++;
    if (obs !== {1'b1, 16'h00FC, 7'b0000000}) begin
      $display("FAIL bp_resume: got %h expected %h", obs, {1'b1, 16'h00FC, 7'b0000000}); n_err++;
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_cen;
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; cmd = 4'd0; opa = 8'h01; opb = 8'h01;
    tick;
    cen = 1'b0; mode = 1'b0; cmd = 4'd4; opa = 8'hFF; opb = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_vec++;
      if (obs !== {1'b1, 16'h0002, 7'b0000000}) begin
        $display("FAIL cen_freeze[%0d]: got %h expected %h", i, obs, {1'b1, 16'h0002, 7'b0000000}); n_err++;
      end
    end
    cen = 1'b1;
    tick;
    n_vec++;
    if (obs !== {1'b1, 16'h00F0, 7'b0000000}) begin
      $display("FAIL cen_resume: got %h expected %h", obs, {1'b1, 16'h00F0, 7'b0000000}); n_err++;
    end
    in_valid = 1'b0;
    tick;
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul;
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; cmd = 4'd7; opa = 8'hFF; opb = 8'hFF;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_vec++;
      if ({in_ready, out_valid} !== 2'b00) begin
        $display("FAIL mul_busy[%0d]: got %b expected 00", k, {in_ready, out_valid}); n_err++;
      end
      tick;
    end
    n_vec++;
    if (obs !== {1'b1, 16'hFE01, 7'b0000000}) begin
      $display("FAIL mul_ff: got %h expected %h", obs, {1'b1, 16'hFE01, 7'b0000000}); n_err++;
    end
    // cen low for 3 edges just after accept stretches latency to 6
    in_valid = 1'b1; opa = 8'h0C; opb = 8'h0D;
    tick;
    in_valid = 1'b0; cen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) cen = 1'b1;
      tick;
      if (k < 6) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          $display("FAIL mul_cen_wait[%0d]: got %b expected 0", k, out_valid); n_err++;
        end
      end
    end
    n_vec++;
    if (obs !== {1'b1, 16'h009C, 7'b0000000}) begin
      $display("FAIL mul_cen: got %h expected %h", obs, {1'b1, 16'h009C, 7'b0000000}); n_err++;
    end
    // reset in flight: immediate idle, product discarded
    in_valid = 1'b1; opa = 8'h03; opb = 8'h05;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, obs} !== {1'b1, 24'h000000}) begin
      $display("FAIL mul_rst: got %h expected %h", {in_ready, obs}, {1'b1, 24'h000000}); n_err++;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL mul_rst_discard: got %b expected 10", {in_ready, out_valid}); n_err++;
    end
  endtask
`else
  task automatic test_mul;
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; cmd = 4'd7; opa = 8'hFF; opb = 8'hFF;
    tick;
    in_valid = 1'b0;
    n_vec++;
    if ({in_ready, obs} !== {1'b1, 1'b1, 16'h0000, 7'b0000001}) begin
      $display("FAIL mul_disabled: got %h expected %h", {in_ready, obs}, {1'b1, 1'b1, 16'h0000, 7'b0000001}); n_err++;
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_back_to_back;
    test_backpressure;
    test_cen;
    test_mul;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
